// File: rtl/omsp_hmac_driver_if.sv
// ---------------------------------------------------------------------------
// omsp_hmac_driver_if
//   Groups the byte-RAM bus and the omsp_hmac start_continue/data_available/
//   busy handshake that omsp_hmac_driver drives.
//
//   Parameters
//     RATE        RAM / HMAC data width in bits
//     ADDR_WIDTH  RAM address width
//
//   Signals (direction as seen by the driver, modport master)
//     mem_addr             out  RAM address
//     mem_rd               out  RAM read strobe, data returns next cycle
//     mem_wr               out  RAM write strobe
//     mem_wdata            out  RAM write data
//     mem_rdata            in   RAM read data
//     hmac_start_continue  out  1-cycle command pulse to the core
//     hmac_data_available  out  qualifies the pulse as a data feed
//     hmac_data_in         out  data chunk to the core
//     hmac_data_out        in   tag chunk from the core
//     hmac_busy            in   core busy
//
//   The slave modport is the RAM + core side.
// ---------------------------------------------------------------------------
interface omsp_hmac_driver_if #(
  parameter int unsigned RATE       = 8,
  parameter int unsigned ADDR_WIDTH = 16
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [RATE-1:0]       mem_wdata;
  logic [RATE-1:0]       mem_rdata;
  logic                  hmac_start_continue;
  logic                  hmac_data_available;
  logic [RATE-1:0]       hmac_data_in;
  logic [RATE-1:0]       hmac_data_out;
  logic                  hmac_busy;

  modport master (
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata,
    output hmac_start_continue,
    output hmac_data_available,
    output hmac_data_in,
    input  hmac_data_out,
    input  hmac_busy
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata,
    input  hmac_start_continue,
    input  hmac_data_available,
    input  hmac_data_in,
    output hmac_data_out,
    output hmac_busy
  );

endinterface

// File: rtl/omsp_hmac_driver.sv
// ---------------------------------------------------------------------------
// omsp_hmac_driver
//   DMA-style sequencer in front of omsp_hmac. Streams msg_len chunks from a
//   byte RAM into the core, issues the pad/finalise command, squeezes
//   TAG_SIZE/RATE tag chunks and either writes them back to RAM at tag_addr
//   or (with HMAC_DRV_VERIFY_EN defined) compares them, in constant time,
//   against the tag stored there.
//
//   Optional feature macro: HMAC_DRV_VERIFY_EN
//     defined   : cmd_verify selects the compare path, ok reports the match
//     undefined : cmd_verify ignored, tag always written, ok tied to 0
//
//   Ports
//     clk, reset     clock, synchronous active-high reset (shared with core)
//     cmd_start      1-cycle start pulse, honoured only while busy=0
//     cmd_verify     compare (1) or write (0) the tag, sampled with cmd_start
//     msg_addr       message base address, sampled with cmd_start
//     msg_len        message length in chunks, sampled with cmd_start
//     tag_addr       tag base address, sampled with cmd_start
//     bus            RAM bus + core handshake (omsp_hmac_driver_if.master)
//     busy           operation in progress
//     done           1-cycle pulse at end of operation
//     ok             verify result, valid while done=1
//     err            1-cycle pulse, command rejected (msg_len=0)
// ---------------------------------------------------------------------------
module omsp_hmac_driver #(
  parameter int unsigned RATE       = 8,
  parameter int unsigned TAG_SIZE   = 128,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic                  cmd_verify,
  input  logic [ADDR_WIDTH-1:0] msg_addr,
  input  logic [LEN_WIDTH-1:0]  msg_len,
  input  logic [ADDR_WIDTH-1:0] tag_addr,
  omsp_hmac_driver_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic                  ok,
  output logic                  err
);

  localparam int unsigned NumChunks = TAG_SIZE / RATE;
  localparam int unsigned ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [ChunkW-1:0] LastChunk = ChunkW'(NumChunks - 1);

  typedef enum logic [3:0] {
    StIdle,
    StMsgRd,
    StMsgFeed,
    StMsgWait,
    StFin,
    StFinWait,
    StSqz,
    StSqzWait,
    StTagWr,
    StTagRd,
    StTagCmp,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] msg_addr_q, msg_addr_d;
  logic [LEN_WIDTH-1:0]  msg_len_q, msg_len_d;
  logic [ADDR_WIDTH-1:0] tag_addr_q, tag_addr_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [ChunkW-1:0]     chunk_idx_q, chunk_idx_d;
  logic [RATE-1:0]       chunk_q, chunk_d;
  logic                  err_q, err_d;

`ifdef HMAC_DRV_VERIFY_EN
  logic                  verify_q, verify_d;
  logic [RATE-1:0]       diff_q, diff_d;
`else
  logic unused_cmd_verify;
  assign unused_cmd_verify = cmd_verify;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      msg_addr_q  <= '0;
      msg_len_q   <= '0;
      tag_addr_q  <= '0;
      idx_q       <= '0;
      chunk_idx_q <= '0;
      chunk_q     <= '0;
      err_q       <= 1'b0;
`ifdef HMAC_DRV_VERIFY_EN
      verify_q    <= 1'b0;
      diff_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      msg_addr_q  <= msg_addr_d;
      msg_len_q   <= msg_len_d;
      tag_addr_q  <= tag_addr_d;
      idx_q       <= idx_d;
      chunk_idx_q <= chunk_idx_d;
      chunk_q     <= chunk_d;
      err_q       <= err_d;
`ifdef HMAC_DRV_VERIFY_EN
      verify_q    <= verify_d;
      diff_q      <= diff_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    msg_addr_d  = msg_addr_q;
    msg_len_d   = msg_len_q;
    tag_addr_d  = tag_addr_q;
    idx_d       = idx_q;
    chunk_idx_d = chunk_idx_q;
    chunk_d     = chunk_q;
    err_d       = 1'b0;
`ifdef HMAC_DRV_VERIFY_EN
    verify_d    = verify_q;
    diff_d      = diff_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          msg_addr_d  = msg_addr;
          msg_len_d   = msg_len;
          tag_addr_d  = tag_addr;
          idx_d       = '0;
          chunk_idx_d = '0;
`ifdef HMAC_DRV_VERIFY_EN
          verify_d    = cmd_verify;
          diff_d      = '0;
`endif
          // The core cannot start a hash without at least one data chunk.
          if (msg_len == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = StMsgRd;
          end
        end
      end
      StMsgRd:   state_d = StMsgFeed;
      StMsgFeed: state_d = StMsgWait;
      StMsgWait: begin
        if (!bus.hmac_busy) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_d == msg_len_q) ? StFin : StMsgRd;
        end
      end
      StFin:     state_d = StFinWait;
      StFinWait: begin
        if (!bus.hmac_busy) state_d = StSqz;
      end
      StSqz:     state_d = StSqzWait;
      StSqzWait: begin
        if (!bus.hmac_busy) begin
          chunk_d = bus.hmac_data_out;
`ifdef HMAC_DRV_VERIFY_EN
          state_d = verify_q ? StTagRd : StTagWr;
`else
          state_d = StTagWr;
`endif
        end
      end
      StTagWr: begin
        if (chunk_idx_q == LastChunk) begin
          chunk_idx_d = '0;
          state_d     = StDone;
        end else begin
          chunk_idx_d = chunk_idx_q + 1'b1;
          state_d     = StSqz;
        end
      end
`ifdef HMAC_DRV_VERIFY_EN
      StTagRd:   state_d = StTagCmp;
      StTagCmp: begin
        // Accumulate every chunk; no early exit keeps timing data-independent.
        diff_d = diff_q | (bus.mem_rdata ^ chunk_q);
        if (chunk_idx_q == LastChunk) begin
          chunk_idx_d = '0;
          state_d     = StDone;
        end else begin
          chunk_idx_d = chunk_idx_q + 1'b1;
          state_d     = StSqz;
        end
      end
`endif
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs, decoded from the registered state only
  always_comb begin
    bus.mem_addr            = '0;
    bus.mem_rd              = 1'b0;
    bus.mem_wr              = 1'b0;
    bus.mem_wdata           = '0;
    bus.hmac_start_continue = 1'b0;
    bus.hmac_data_available = 1'b0;
    bus.hmac_data_in        = '0;
    busy                    = (state_q != StIdle);
    done                    = 1'b0;
    ok                      = 1'b0;
    err                     = err_q;
    unique case (state_q)
      StMsgRd: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = msg_addr_q + ADDR_WIDTH'(idx_q);
      end
      StMsgFeed: begin
        bus.hmac_start_continue = 1'b1;
        bus.hmac_data_available = 1'b1;
        bus.hmac_data_in        = bus.mem_rdata;
      end
      StFin, StSqz: bus.hmac_start_continue = 1'b1;
      StTagWr: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = tag_addr_q + ADDR_WIDTH'(chunk_idx_q);
        bus.mem_wdata = chunk_q;
      end
`ifdef HMAC_DRV_VERIFY_EN
      StTagRd: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = tag_addr_q + ADDR_WIDTH'(chunk_idx_q);
      end
`endif
      StDone: begin
        done = 1'b1;
`ifdef HMAC_DRV_VERIFY_EN
        ok   = verify_q & (diff_q == '0);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_omsp_hmac_driver.sv
`timescale 1ns/1ps
// Bench for omsp_hmac_driver. A behavioural stand-in for omsp_hmac (toy
// absorb/pad/squeeze function with varying busy latency) and a byte RAM
// surround the DUT. Expected RAM writes, done/ok and err pulses are queued at
// stimulus time; a monitor pops and compares whenever the DUT presents one.
module tb_omsp_hmac_driver;

  localparam int unsigned RATE       = 8;
  localparam int unsigned TAG_SIZE   = 128;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned LEN_WIDTH  = 16;
  localparam int          NumChunks  = TAG_SIZE / RATE;

  typedef enum int {EvWr, EvDone, EvErr} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_verify = 1'b0;
  logic [15:0] msg_addr = '0;
  logic [15:0] msg_len = '0;
  logic [15:0] tag_addr = '0;
  logic        busy, done, ok, err;

  omsp_hmac_driver_if #(.RATE(RATE), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  omsp_hmac_driver #(
    .RATE(RATE), .TAG_SIZE(TAG_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_verify(cmd_verify),
    .msg_addr(msg_addr), .msg_len(msg_len), .tag_addr(tag_addr), .bus(bus),
    .busy(busy), .done(done), .ok(ok), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:65535];
  ev_t         sb[$];
  logic [15:0] rd_addrs[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          n_feed = 0, n_pad = 0, n_sqz = 0, n_pulse = 0;
  logic [7:0]  c_acc;
  logic        c_fin;
  int          c_sq, c_lat;

  function automatic logic [7:0] next_acc(input logic [7:0] a, input logic [7:0] d);
    return {a[6:0], a[7]} ^ d ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sq_byte(input logic [7:0] a, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return (a + kk * 8'd29) ^ 8'hC3;
  endfunction

  // Reference tag over the bench's own RAM image
  task automatic golden(input logic [15:0] ma, input int len, output logic [127:0] t);
    logic [7:0]  a;
    logic [15:0] p;
    a = 8'h00;
    for (int i = 0; i < len; i++) begin
      p = ma + 16'(i);
      a = next_acc(a, ram[p]);
    end
    a = a ^ 8'h3C;
    for (int k = 0; k < NumChunks; k++) t[k*8 +: 8] = sq_byte(a, k);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input ev_kind_e k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required none", k, a, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d) begin
        n_fail++;
        $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Core stand-in and RAM, updated on the rising edge
  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (bus.mem_wr) ram[bus.mem_addr] = bus.mem_wdata;
      if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
      if (reset) begin
        bus.hmac_busy     <= 1'b0;
        bus.hmac_data_out <= '0;
        c_acc = 8'h00; c_fin = 1'b0; c_sq = 0; c_lat = 0;
      end else if (bus.hmac_start_continue) begin
        n_pulse++;
        c_lat = 1 + (n_pulse % 3);
        bus.hmac_busy <= 1'b1;
        if (bus.hmac_data_available) begin
          c_acc = next_acc(c_fin ? 8'h00 : c_acc, bus.hmac_data_in);
          c_fin = 1'b0; c_sq = 0; n_feed++;
        end else if (!c_fin) begin
          c_acc = c_acc ^ 8'h3C; c_fin = 1'b1; n_pad++;
        end else begin
          bus.hmac_data_out <= sq_byte(c_acc, c_sq);
          c_sq++; n_sqz++;
        end
      end else if (c_lat > 1) begin
        c_lat--;
      end else begin
        bus.hmac_busy <= 1'b0;
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.mem_rd) rd_addrs.push_back(bus.mem_addr);
        if (bus.mem_wr) sb_pop(EvWr, bus.mem_addr, bus.mem_wdata);
        if (done) begin
          done_cnt++;
          sb_pop(EvDone, 16'h0000, {7'b0, ok});
        end
        if (err) sb_pop(EvErr, 16'h0000, 8'h00);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected response, then pulse cmd_start for one cycle.
  task automatic issue(input logic vfy, input logic [15:0] ma, input logic [15:0] ln,
                       input logic [15:0] ta, input logic exp_ok, input int nwr,
                       input logic push_done);
    logic [127:0] t;
    logic         eff;
    golden(ma, int'(ln), t);
`ifdef HMAC_DRV_VERIFY_EN
    eff = vfy;
`else
    eff = 1'b0;
`endif
    if (!eff) for (int k = 0; k < nwr; k++) push(EvWr, ta + 16'(k), t[k*8 +: 8]);
    if (push_done) push(EvDone, 16'h0000, {7'b0, eff & exp_ok});
    cmd_start = 1'b1; cmd_verify = vfy; msg_addr = ma; msg_len = ln; tag_addr = ta;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      tick();
      i++;
    end
    check(name, 32'(done_cnt != d0), 32'd1);
  endtask

  initial begin
    logic [127:0] t;
    int           s_feed, s_pad, s_sqz, s_pulse, r0, d0, cnt;
    logic         any_busy;

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    fork
      model_loop();
      monitor_loop();
    join_none

    // Reset state
    repeat (3) tick();
    check("reset_status", {28'h0, busy, done, ok, err}, 32'h0);
    check("reset_bus", {28'h0, bus.mem_rd, bus.mem_wr, bus.hmac_start_continue,
                        bus.hmac_data_available}, 32'h0);
    reset = 1'b0;
    tick();

    // Hand-computed reference for "abc": acc 3B,4E,A5, pad -> 99
    ram[16'h0100] = 8'h61; ram[16'h0101] = 8'h62; ram[16'h0102] = 8'h63;
    golden(16'h0100, 3, t);
    check("golden_chunk0", {24'h0, t[7:0]}, 32'h5A);
    check("golden_chunk15", {24'h0, t[127:120]}, 32'h8F);

    // Write mode, 3-byte message
    s_feed = n_feed; s_pad = n_pad; s_sqz = n_sqz;
    issue(1'b0, 16'h0100, 16'd3, 16'h0200, 1'b0, NumChunks, 1'b1);
    wait_done("write_done", 2000);
    check("feed_pulses", 32'(n_feed - s_feed), 32'd3);
    check("pad_pulses", 32'(n_pad - s_pad), 32'd1);
    check("squeeze_pulses", 32'(n_sqz - s_sqz), 32'd16);
    check("ram_tag0", {24'h0, ram[16'h0200]}, 32'h5A);
    check("ram_tag15", {24'h0, ram[16'h020F]}, 32'h8F);

    // Zero length is rejected
    s_pulse = n_pulse;
    push(EvErr, 16'h0000, 8'h00);
    cmd_start = 1'b1; msg_addr = 16'h0100; msg_len = 16'd0; tag_addr = 16'h0200;
    any_busy = busy;
    tick();
    cmd_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      any_busy |= busy;
      tick();
    end
    check("len0_busy", {31'h0, any_busy}, 32'h0);
    check("len0_pulses", 32'(n_pulse - s_pulse), 32'd0);
    check("len0_err_seen", 32'(sb.size()), 32'd0);

    // Verify against the correct stored tag
    r0 = rd_addrs.size();
    issue(1'b1, 16'h0100, 16'd3, 16'h0200, 1'b1, NumChunks, 1'b1);
    wait_done("verify_ok_done", 2000);
`ifdef HMAC_DRV_VERIFY_EN
    check("verify_ok_reads", 32'(rd_addrs.size() - r0), 32'd19);
`else
    check("verify_ok_reads", 32'(rd_addrs.size() - r0), 32'd3);
`endif

    // Verify with bit 0 of the last tag byte flipped
    ram[16'h020F] = ram[16'h020F] ^ 8'h01;
    r0 = rd_addrs.size();
    issue(1'b1, 16'h0100, 16'd3, 16'h0200, 1'b0, NumChunks, 1'b1);
    wait_done("verify_bad_done", 2000);
    cnt = 0;
    for (int i = r0; i < rd_addrs.size(); i++)
      if (rd_addrs[i] >= 16'h0200 && rd_addrs[i] <= 16'h020F) cnt++;
`ifdef HMAC_DRV_VERIFY_EN
    check("verify_bad_tag_reads", 32'(cnt), 32'd16);
`else
    check("verify_bad_tag_reads", 32'(cnt), 32'd0);
`endif

    // cmd_start re-asserted mid-message must be ignored
    issue(1'b0, 16'h0100, 16'd3, 16'h0300, 1'b0, NumChunks, 1'b1);
    repeat (4) tick();
    cmd_start = 1'b1; cmd_verify = 1'b1; msg_addr = 16'h0150; msg_len = 16'd7;
    tag_addr = 16'h0500;
    tick();
    cmd_start = 1'b0;
    wait_done("disturb_done", 2000);
    check("disturb_tag0", {24'h0, ram[16'h0300]}, 32'h5A);

    // Reset while waiting on the 5th squeeze: only chunks 0..3 get written
    s_sqz = n_sqz;
    issue(1'b0, 16'h0100, 16'd3, 16'h0600, 1'b0, 4, 1'b0);
    cnt = 0;
    while (n_sqz - s_sqz < 5 && cnt < 2000) begin
      tick();
      cnt++;
    end
    check("reach_sqz_wait", 32'(n_sqz - s_sqz), 32'd5);
    reset = 1'b1;
    tick();
    check("abort_status", {28'h0, busy, done, ok, err}, 32'h0);
    check("abort_bus", {12'h0, bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.hmac_start_continue,
                        bus.hmac_data_available}, 32'h0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (60) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_queue", 32'(sb.size()), 32'd0);
    issue(1'b0, 16'h0100, 16'd3, 16'h0600, 1'b0, NumChunks, 1'b1);
    wait_done("rerun_done", 2000);
    check("rerun_tag15", {24'h0, ram[16'h060F]}, 32'h8F);

    // Message address wraps from FFFF to 0000
    ram[16'hFFFF] = 8'h11; ram[16'h0000] = 8'h22;
    r0 = rd_addrs.size();
    issue(1'b0, 16'hFFFF, 16'd2, 16'h0400, 1'b0, NumChunks, 1'b1);
    wait_done("wrap_done", 2000);
    check("wrap_nreads", 32'(rd_addrs.size() >= r0 + 2), 32'd1);
    if (rd_addrs.size() >= r0 + 2) begin
      check("wrap_addr0", {16'h0, rd_addrs[r0]}, 32'h0000FFFF);
      check("wrap_addr1", {16'h0, rd_addrs[r0+1]}, 32'h00000000);
    end

    repeat (5) tick();
    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
